// File: rtl/reg_pkg.sv
// Shared definitions for readers of the 8 x 16-bit register bank.
package reg_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned IDXW = $clog2(NREG);
    localparam int unsigned BUSW = NREG * DW;

    typedef logic [IDXW-1:0] reg_idx_t;
    typedef logic [DW-1:0]   reg_data_t;
    typedef logic [NREG-1:0] reg_mask_t;
    typedef logic [BUSW-1:0] reg_bus_t;

    // Output slot of the read port; FULL is exactly rsp_valid.
    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } slot_state_e;

    // Register idx out of the bank's flattened output bus.
    function automatic reg_data_t get_reg(input reg_bus_t bus, input reg_idx_t idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard with hazard query for two sources and one destination.
module reg_scoreboard
    import reg_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      set_en_i,
    input  reg_idx_t  set_idx_i,
    input  reg_mask_t clr_i,
    input  reg_idx_t  qa_i,
    input  reg_idx_t  qb_i,
    input  reg_idx_t  qd_i,
    input  logic      qd_en_i,
    output reg_mask_t pending_o,
    output logic      haz_o
);

    reg_mask_t pending_q, pending_d;

    // Per-bit set/clear; a new claim is younger than the retiring write so set wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < int'(NREG); i++) begin
            if (set_en_i && (set_idx_i == reg_idx_t'(i))) begin
                pending_d[i] = 1'b1;
            end else if (clr_i[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A pending register retiring this cycle is not a hazard: its value is forwarded.
    always_comb begin
        haz_o = (pending_q[qa_i] & ~clr_i[qa_i])
              | (pending_q[qb_i] & ~clr_i[qb_i])
              | (qd_en_i & pending_q[qd_i] & ~clr_i[qd_i]);
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/register_read_port.sv
// Operand read port: forwards write-back data, stalls on RAW/WAW, holds operands for execute.
module register_read_port
    import reg_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      req_valid_i,
    output logic      req_ready_o,
    input  reg_idx_t  rs_a_i,
    input  reg_idx_t  rs_b_i,
    input  reg_idx_t  rd_i,
    input  logic      rd_claim_i,
    input  reg_bus_t  bank_q_i,
    input  reg_mask_t wb_en_i,
    input  reg_data_t wb_data_i,
    output logic      rsp_valid_o,
    input  logic      rsp_ready_i,
    output reg_data_t op_a_o,
    output reg_data_t op_b_o,
    output reg_mask_t pending_o
);

    slot_state_e state_q, state_d;
    reg_data_t   op_a_q, op_a_d;
    reg_data_t   op_b_q, op_b_d;
    reg_data_t   fwd_a, fwd_b;
    logic        haz;
    logic        accept;

    reg_scoreboard u_scoreboard (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_en_i  (accept & rd_claim_i),
        .set_idx_i (rd_i),
        .clr_i     (wb_en_i),
        .qa_i      (rs_a_i),
        .qb_i      (rs_b_i),
        .qd_i      (rd_i),
        .qd_en_i   (rd_claim_i),
        .pending_o (pending_o),
        .haz_o     (haz)
    );

    // The bank's Q lags wb_en by one edge, so same-cycle write-back must bypass it.
    always_comb begin
        fwd_a = wb_en_i[rs_a_i] ? wb_data_i : get_reg(bank_q_i, rs_a_i);
        fwd_b = wb_en_i[rs_b_i] ? wb_data_i : get_reg(bank_q_i, rs_b_i);
    end

    assign rsp_valid_o = (state_q == StFull);
    assign req_ready_o = ~haz & (~rsp_valid_o | rsp_ready_i);
    assign accept      = req_valid_i & req_ready_o;

    // Slot next-state and operand capture; operands only change on accept.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        if (accept) begin
            op_a_d = fwd_a;
            op_b_d = fwd_b;
        end
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (rsp_ready_i && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Slot and operand registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign op_a_o = op_a_q;
    assign op_b_o = op_b_q;

endmodule
